// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-port memory. Port 0 is instruction fetch and
// port 1 is data load/store. One transaction runs at a time through the
// sequence IDLE -> ISSUE -> WAIT -> RESP. When both ports request together,
// the grant alternates between them.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mux_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // The read data is valid in the WAIT cycle where cnt reaches this value.
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        last_gnt;
  logic        we_lat;
  logic        winner;
  logic        accept;
  logic        capture;

  // Arbitration: a lone requester wins; on a tie, the port not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_gnt;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
    req0_ready = (state == IDLE) && req0_valid && !winner;
    req1_ready = (state == IDLE) && req1_valid && winner;
    accept     = req0_ready || req1_ready;
    capture    = (state == WAIT) && (cnt == LAT);
  end

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the transaction sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == LAT) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter: starts at 1 when leaving ISSUE, stops at LAT, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else begin
      case (state)
        ISSUE:   cnt <= 4'd1;
        WAIT:    if (cnt != LAT) cnt <= cnt + 4'd1;
        default: cnt <= 4'd0;
      endcase
    end
  end

  // On acceptance, load the winner's request into the memory-side registers.
  // These registers are already driving the memory during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      mux_sel   <= 1'b0;
      we_lat    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept && (winner ? req1_we : req0_we);
      if (accept) begin
        last_gnt  <= winner;
        mux_sel   <= winner;
        we_lat    <= winner ? req1_we : req0_we;
        mem_addr  <= winner ? req1_addr : req0_addr;
        mem_wdata <= winner ? req1_wdata : req0_wdata;
      end
    end
  end

  // Capture the memory data into the granted port's response register.
  // A write returns zero. rvalid pulses during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      req0_rvalid <= capture && !mux_sel;
      req1_rvalid <= capture && mux_sel;
      if (capture && !mux_sel) req0_rdata <= we_lat ? '0 : mem_rdata;
      if (capture && mux_sel)  req1_rdata <= we_lat ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter. Three instances use MEM_LAT = 2, 1
// and 15. Each instance is checked against a transaction-level model that
// tracks the following for every cycle:
//   - when the shared port is free,
//   - when the access is issued,
//   - when the response is due.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  // Memory contents as a pure function of the address. 0x40 holds a known word.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h40) return 32'hDEADBEEF;
    return (addr * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lat
      localparam int ML = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);

      logic        rst_n;
      logic        req0_valid, req0_we, req0_ready, req0_rvalid;
      logic [31:0] req0_addr, req0_wdata, req0_rdata;
      logic        req1_valid, req1_we, req1_ready, req1_rvalid;
      logic [31:0] req1_addr, req1_wdata, req1_rdata;
      logic        mux_sel, mem_en, mem_we, busy;
      logic [31:0] mem_addr, mem_wdata, mem_rdata;

      mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_we(req0_we), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_we(req1_we), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .mux_sel(mux_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
      );

      // Pending request per port, owned by the bench.
      logic        v [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      logic        w [2];

      // Reference-model state.
      int          cyc, free_at, issue_cyc, resp_cyc, nacc, mode;
      int          rst_left, mark_cyc, mark_idx, mark_nacc;
      logic        lg, exp_sel, resp_port, iss_we;
      logic [31:0] iss_addr, iss_wdata, resp_data, exp_maddr, exp_mwd;
      logic [31:0] exp_rd [2];
      int          gnt_q [$];
      string       pfx;

      task automatic post(input int p, input logic [31:0] addr, input logic [31:0] wd,
                          input logic we);
        if (!v[p]) begin
          v[p] = 1'b1; a[p] = addr; d[p] = wd; w[p] = we;
        end
      endtask

      task automatic rand_post(input int p);
        if (!v[p] && $urandom_range(1, 0) == 1)
          post(p, $urandom, $urandom, $urandom_range(2, 0) == 0);
        else if (v[p] && $urandom_range(15, 0) == 0)
          v[p] = 1'b0;
      endtask

      task automatic apply();
        req0_valid = v[0]; req0_addr = a[0]; req0_wdata = d[0]; req0_we = w[0];
        req1_valid = v[1]; req1_addr = a[1]; req1_wdata = d[1]; req1_we = w[1];
      endtask

      task automatic model_reset();
        free_at = 0; lg = 1'b1; exp_sel = 1'b0; exp_maddr = '0; exp_mwd = '0;
        exp_rd[0] = '0; exp_rd[1] = '0; issue_cyc = -100; resp_cyc = -100;
        resp_port = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
      endtask

      task automatic check_order(input int idx, input int exp_port, input string tag);
        int got;
        got = (idx < gnt_q.size()) ? gnt_q[idx] : 7;
        check({pfx, tag}, 32'(got), 32'(exp_port));
      endtask

      initial begin : run
        logic idle, has, win, e_r0, e_r1;
        pfx = $sformatf("L%0d.", ML);
        a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0; w[0] = 1'b0; w[1] = 1'b0;
        model_reset();
        cyc = 0; nacc = 0; mode = 0; rst_left = 0; mark_cyc = 0; mark_idx = 0; mark_nacc = 0;
        iss_addr = '0; iss_wdata = '0; iss_we = 1'b0; resp_data = '0;
        rst_n = 1'b0; mem_rdata = '0;
        apply();
        repeat (2) @(posedge clk);
        #1;
        check({pfx, "rst.ready0"},  32'(req0_ready),  32'd0);
        check({pfx, "rst.ready1"},  32'(req1_ready),  32'd0);
        check({pfx, "rst.rvalid0"}, 32'(req0_rvalid), 32'd0);
        check({pfx, "rst.rvalid1"}, 32'(req1_rvalid), 32'd0);
        check({pfx, "rst.rdata0"},  req0_rdata,       32'd0);
        check({pfx, "rst.rdata1"},  req1_rdata,       32'd0);
        check({pfx, "rst.mux_sel"}, 32'(mux_sel),     32'd0);
        check({pfx, "rst.mem_en"},  32'(mem_en),      32'd0);
        check({pfx, "rst.mem_we"},  32'(mem_we),      32'd0);
        check({pfx, "rst.mem_addr"}, mem_addr,        32'd0);
        check({pfx, "rst.mem_wdata"}, mem_wdata,      32'd0);
        check({pfx, "rst.busy"},    32'(busy),        32'd0);
        rst_n = 1'b1;

        while (mode != 8 && cyc < 4000) begin
          @(posedge clk);
          cyc++;
          #1;
          // The memory returns valid data only in its single valid cycle.
          mem_rdata = (cyc == issue_cyc + ML) ? mem_word(mem_addr) : $urandom;

          if (mode == 5 && cyc == issue_cyc + 1) begin
            // Assert reset during the first WAIT cycle; the transaction is dropped.
            rst_n = 1'b0;
            model_reset();
            apply();
            #1;
            check({pfx, "arst.mem_en"},  32'(mem_en),      32'd0);
            check({pfx, "arst.busy"},    32'(busy),        32'd0);
            check({pfx, "arst.rvalid0"}, 32'(req0_rvalid), 32'd0);
            check({pfx, "arst.rvalid1"}, 32'(req1_rvalid), 32'd0);
            check({pfx, "arst.rdata0"},  req0_rdata,       32'd0);
            check({pfx, "arst.rdata1"},  req1_rdata,       32'd0);
            rst_left = 2;
            mode = 6;
          end else if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) begin
              rst_n = 1'b1;
              mark_nacc = nacc;
              mark_idx = gnt_q.size();
            end
          end

          if (rst_n) begin
            if (mode == 0 && nacc >= 1) mode = 1;
            if (mode == 1 && nacc >= 2) begin
              mode = 2;
              mark_idx = gnt_q.size();
            end
            if (mode == 2 && nacc >= 6) begin
              for (int k = 0; k < 4; k++) check_order(mark_idx + k, k % 2, "order.rr");
              v[0] = 1'b0;
              mode = 3;
            end
            if (mode == 3 && nacc >= 10) begin
              mode = 4;
              mark_cyc = cyc;
            end
            if (mode == 4 && cyc - mark_cyc >= 300) mode = 5;
            if (mode == 6 && nacc >= mark_nacc + 2) begin
              check_order(mark_idx, 0, "order.after_rst0");
              check_order(mark_idx + 1, 1, "order.after_rst1");
              mode = 7;
              mark_cyc = cyc;
            end
            if (mode == 7 && cyc - mark_cyc >= 100) mode = 8;

            case (mode)
              0: if (nacc == 0) post(0, 32'h40, 32'h0, 1'b0);
              1: if (nacc == 1) post(1, 32'h100, 32'h12345678, 1'b1);
              2, 6: begin
                post(0, $urandom, $urandom, 1'b0);
                post(1, $urandom, $urandom, 1'b0);
              end
              3: post(1, $urandom, $urandom, 1'b0);
              8: ;
              default: begin
                rand_post(0);
                rand_post(1);
              end
            endcase
          end
          apply();

          @(negedge clk);
          if (cyc == issue_cyc) begin
            exp_sel = resp_port; exp_maddr = iss_addr; exp_mwd = iss_wdata;
          end
          if (cyc == resp_cyc) exp_rd[resp_port] = resp_data;
          idle = (cyc >= free_at);
          has  = v[0] || v[1];
          win  = (v[0] && v[1]) ? !lg : v[1];
          e_r0 = idle && has && !win;
          e_r1 = idle && has && win;

          check({pfx, "ready0"},    32'(req0_ready),  32'(e_r0));
          check({pfx, "ready1"},    32'(req1_ready),  32'(e_r1));
          check({pfx, "busy"},      32'(busy),        32'(!idle));
          check({pfx, "mem_en"},    32'(mem_en),      32'(cyc == issue_cyc));
          check({pfx, "mem_we"},    32'(mem_we),      32'((cyc == issue_cyc) && iss_we));
          check({pfx, "mem_addr"},  mem_addr,         exp_maddr);
          check({pfx, "mem_wdata"}, mem_wdata,        exp_mwd);
          check({pfx, "mux_sel"},   32'(mux_sel),     32'(exp_sel));
          check({pfx, "rvalid0"},   32'(req0_rvalid), 32'((cyc == resp_cyc) && !resp_port));
          check({pfx, "rvalid1"},   32'(req1_rvalid), 32'((cyc == resp_cyc) && resp_port));
          check({pfx, "rdata0"},    req0_rdata,       exp_rd[0]);
          check({pfx, "rdata1"},    req1_rdata,       exp_rd[1]);

          if (req0_valid && req0_ready) gnt_q.push_back(0);
          if (req1_valid && req1_ready) gnt_q.push_back(1);

          if (e_r0 || e_r1) begin
            lg        = win;
            resp_port = win;
            iss_addr  = a[win];
            iss_wdata = d[win];
            iss_we    = w[win];
            issue_cyc = cyc + 1;
            resp_cyc  = cyc + ML + 2;
            free_at   = cyc + ML + 3;
            resp_data = w[win] ? 32'h0 : mem_word(a[win]);
            v[win]    = 1'b0;
            nacc++;
            $display("%sT%0d port%0d %s addr=%h wdata=%h expect rdata=%h at T%0d",
                     pfx, cyc, win, iss_we ? "WR" : "RD", iss_addr, iss_wdata,
                     resp_data, resp_cyc);
          end
        end
        check({pfx, "finished"}, 32'(mode), 32'd8);
        n_done++;
      end
    end
  endgenerate

  initial begin
    wait (n_done == 3);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
